// File: rtl/pulse_gen_pkg.sv
// ----------------------------------------------------------------------------
// pulse_gen_pkg
// Shared definitions for the multi-channel pulse generator.
//   MIN_PERIOD  : shortest period (in strobes) a channel may be loaded with
//   ch_state_e  : per-channel phase (not yet started / running)
//   load_ok()   : width-generic validation of a load request
// The per-channel {period, high} config struct depends on CNT_W. It is
// declared inside pulse_gen_ch so it can use that parameter; load_ok()
// takes zero-extended 64-bit operands, which covers any CNT_W <= 64.
// ----------------------------------------------------------------------------
package pulse_gen_pkg;

  localparam int unsigned MIN_PERIOD = 2;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // A load is only taken if it addresses an existing channel and describes
  // a waveform the channel counter can represent (period >= 2, high <= period).
  function automatic logic load_ok(input logic [31:0] ch,
                                   input logic [31:0] num_ch,
                                   input logic [63:0] period,
                                   input logic [63:0] high);
    return (ch < num_ch) && (period >= 64'(MIN_PERIOD)) && (high <= period);
  endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// ----------------------------------------------------------------------------
// pulse_gen_ch
// One channel of the pulse generator: period counter, active and shadow
// {period, high} registers, start-up phase, registered wave and tick.
//
// State table
//   state   | meaning
//   CH_IDLE | after reset; the next strobe always starts a new period
//   CH_RUN  | counting within a period; a wrap happens at cnt == period-1
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   ce         in   counting strobe shared by all channels
//   ld         in   accepted load for this channel (already validated)
//   ld_period  in   new period in strobes
//   ld_high    in   new high time in strobes
//   wave       out  registered waveform
//   tick       out  one-cycle pulse at the start of every period
// ----------------------------------------------------------------------------
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned DEF_PERIOD = 8,
  parameter int unsigned DEF_HIGH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_period,
  input  logic [CNT_W-1:0] ld_high,
  output logic             wave,
  output logic             tick
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{period: CNT_W'(DEF_PERIOD), high: CNT_W'(DEF_HIGH)};

  ch_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  cfg_t             active, active_nxt;
  cfg_t             shadow, shadow_nxt;
  cfg_t             ld_cfg;
  cfg_t             incoming;
  logic             wave_nxt;
  logic             tick_nxt;
  logic             wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CH_IDLE;
      cnt    <= '0;
      active <= DEF_CFG;
      shadow <= DEF_CFG;
      wave   <= 1'b0;
      tick   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      active <= active_nxt;
      shadow <= shadow_nxt;
      wave   <= wave_nxt;
      tick   <= tick_nxt;
    end
  end

  always_comb begin
    ld_cfg.period = ld_period;
    ld_cfg.high   = ld_high;
    // A load arriving on the wrapping strobe goes straight into active.
    incoming   = ld ? ld_cfg : shadow;
    cnt_inc    = cnt + CNT_W'(1);
    wrap       = (state == CH_IDLE) || (cnt == active.period - CNT_W'(1));

    state_nxt  = state;
    cnt_nxt    = cnt;
    active_nxt = active;
    shadow_nxt = incoming;
    wave_nxt   = wave;
    tick_nxt   = 1'b0;

    if (ce) begin
      if (wrap) begin
        state_nxt  = CH_RUN;
        cnt_nxt    = '0;
        active_nxt = incoming;
        tick_nxt   = 1'b1;
        wave_nxt   = (incoming.high != '0);
      end else begin
        cnt_nxt    = cnt_inc;
        wave_nxt   = (cnt_inc < active.high);
      end
    end
  end

endmodule

// File: rtl/multi_ch_pulse_gen.sv
// ----------------------------------------------------------------------------
// multi_ch_pulse_gen
// NUM_CH independent periodic waveforms driven from one shared counting
// strobe. Each channel has its own period and high time (in strobes),
// reloadable at run time through shadow registers that take effect at the
// channel's next period start, plus a one-cycle start-of-period tick.
//
// Build option
//   PULSE_GEN_PRESCALER_EN defined   : strobe every PRESCALE enabled clocks
//   PULSE_GEN_PRESCALER_EN undefined : strobe on every enabled clock, no
//                                      prescaler logic, PRESCALE ignored
//
// Ports
//   i_clk        in   system clock (only clock)
//   i_rst_n      in   asynchronous active-low reset
//   i_en         in   global run enable; low freezes all state and outputs
//   i_ld         in   one-cycle load strobe
//   i_ld_ch      in   target channel of the load
//   i_ld_period  in   new period in strobes (>= 2)
//   i_ld_high    in   new high time in strobes (<= period)
//   o_ld_err     out  one-cycle pulse, one clock after a rejected load
//   o_wave       out  per-channel waveform
//   o_tick       out  per-channel start-of-period pulse
// CLK_FREQ documents the clock rate and only feeds the DEF_PERIOD default.
// ----------------------------------------------------------------------------
module multi_ch_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned DEF_PERIOD = CLK_FREQ / PRESCALE,
  parameter int unsigned DEF_HIGH   = DEF_PERIOD / 2
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst_n,
  input  logic                                            i_en,
  input  logic                                            i_ld,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  i_ld_ch,
  input  logic [CNT_W-1:0]                                i_ld_period,
  input  logic [CNT_W-1:0]                                i_ld_high,
  output logic                                            o_ld_err,
  output logic [NUM_CH-1:0]                               o_wave,
  output logic [NUM_CH-1:0]                               o_tick
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic ce;
  logic ld_valid;
  logic ld_ok;

`ifdef PULSE_GEN_PRESCALER_EN
  localparam int unsigned PRESC_W = $clog2(PRESCALE);

  logic [PRESC_W-1:0] presc;

  assign ce = i_en && (presc == PRESC_W'(PRESCALE - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc <= '0;
    end else if (ce) begin
      presc <= '0;
    end else if (i_en) begin
      presc <= presc + PRESC_W'(1);
    end
  end
`else
  assign ce = i_en;
`endif

  assign ld_valid = load_ok(32'(i_ld_ch), NUM_CH, 64'(i_ld_period), 64'(i_ld_high));
  assign ld_ok    = i_ld && ld_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ld_err <= 1'b0;
    end else begin
      o_ld_err <= i_ld && !ld_valid;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ld_sel;

    assign ld_sel = ld_ok && (i_ld_ch == CH_W'(g));

    pulse_gen_ch #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_ch (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .ce         (ce),
      .ld         (ld_sel),
      .ld_period  (i_ld_period),
      .ld_high    (i_ld_high),
      .wave       (o_wave[g]),
      .tick       (o_tick[g])
    );
  end

endmodule

// File: tb/tb_multi_ch_pulse_gen.sv
// ----------------------------------------------------------------------------
// tb_multi_ch_pulse_gen
// Self-checking bench for multi_ch_pulse_gen. The reference model counts
// enabled clocks since reset and remembers, per channel, the clock at which
// the current period began; wave and tick follow from elapsed time against
// period*prescale and high*prescale. Works with PULSE_GEN_PRESCALER_EN
// either defined (prescale 4) or undefined (prescale 1).
// Three channels are used so that an out-of-range channel index (3) is
// representable on the 2-bit channel port.
// ----------------------------------------------------------------------------
module tb_multi_ch_pulse_gen;

  localparam int PRESCALE = 4;
  localparam int NCH      = 3;
  localparam int CW       = 8;
  localparam int DP       = 8;
  localparam int DH       = 4;
`ifdef PULSE_GEN_PRESCALER_EN
  localparam int PS = PRESCALE;
`else
  localparam int PS = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           ld = 1'b0;
  logic [1:0]     ld_ch = '0;
  logic [CW-1:0]  ld_period = '0;
  logic [CW-1:0]  ld_high = '0;
  logic           ld_err;
  logic [NCH-1:0] wave;
  logic [NCH-1:0] tick;

  always #5 clk = ~clk;

  multi_ch_pulse_gen #(
    .CLK_FREQ   (1000),
    .PRESCALE   (PRESCALE),
    .NUM_CH     (NCH),
    .CNT_W      (CW),
    .DEF_PERIOD (DP),
    .DEF_HIGH   (DH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_ld        (ld),
    .i_ld_ch     (ld_ch),
    .i_ld_period (ld_period),
    .i_ld_high   (ld_high),
    .o_ld_err    (ld_err),
    .o_wave      (wave),
    .o_tick      (tick)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int t;
  int t0      [NCH];
  bit started [NCH];
  int per     [NCH];
  int hi      [NCH];
  int sh_per  [NCH];
  int sh_hi   [NCH];
  logic [NCH-1:0] e_wave;
  logic [NCH-1:0] e_tick;
  logic           e_err;

  function automatic void model_reset();
    t = 0;
    for (int c = 0; c < NCH; c++) begin
      t0[c] = 0; started[c] = 1'b0;
      per[c] = DP; hi[c] = DH; sh_per[c] = DP; sh_hi[c] = DH;
    end
    e_wave = '0; e_tick = '0; e_err = 1'b0;
  endfunction

  // Called at every rising edge with reset released.
  function automatic void model_edge();
    int p, h, c_ld;
    p = int'(ld_period); h = int'(ld_high); c_ld = int'(ld_ch);
    e_err  = ld && !(c_ld < NCH && p >= 2 && h <= p);
    e_tick = '0;
    if (ld && !e_err) begin
      sh_per[c_ld] = p;
      sh_hi[c_ld]  = h;
    end
    if (en) begin
      t++;
      for (int c = 0; c < NCH; c++) begin
        if (started[c] ? (t - t0[c] == per[c] * PS) : (t % PS == 0)) begin
          t0[c] = t; per[c] = sh_per[c]; hi[c] = sh_hi[c];
          started[c] = 1'b1; e_tick[c] = 1'b1;
        end
      end
    end
    for (int c = 0; c < NCH; c++)
      e_wave[c] = started[c] && ((t - t0[c]) < hi[c] * PS);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("wave",   32'(wave),   32'(e_wave));
    check("tick",   32'(tick),   32'(e_tick));
    check("ld_err", 32'(ld_err), 32'(e_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int c, input int p, input int h);
    ld = 1'b1; ld_ch = 2'(c); ld_period = CW'(p); ld_high = CW'(h);
    step();
    ld = 1'b0;
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must drop at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_wave",   32'(wave),   32'h0);
    check("rst_tick",   32'(tick),   32'h0);
    check("rst_ld_err", 32'(ld_err), 32'h0);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic measure_first_tick(input string tag);
    int k;
    bit seen;
    k = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      k++;
      if (tick[0] === 1'b1) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'h1);
    if (seen) check({tag, "_cycle"}, 32'(k), 32'(PS));
  endtask

  task automatic measure_tick_interval(input string tag, input int exp);
    int k;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (tick[0] === 1'b1) seen = 1'b1;
    end
    check({tag, "_sync"}, 32'(seen), 32'h1);
    k = 0; seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      k++;
      if (tick[0] === 1'b1) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'h1);
    if (seen) check({tag, "_clocks"}, 32'(k), 32'(exp));
  endtask

  initial begin
    model_reset();
    #23;
    check("reset_wave",   32'(wave),   32'h0);
    check("reset_tick",   32'(tick),   32'h0);
    check("reset_ld_err", 32'(ld_err), 32'h0);
    en = 1'b1;
    rst_n = 1'b1;

    // Default waveform from reset.
    measure_first_tick("first_tick");
    run(3 * DP * PS);
    measure_tick_interval("def_period", DP * PS);

    // Mid-period reload of ch1; takes effect at its next wrap.
    run(3 * PS);
    load(1, 5, 1);
    run(4 * DP * PS);

    // Rejected loads.
    load(0, 1, 0);
    check("rej_period1", 32'(ld_err), 32'h1);
    load(0, 8, 9);
    check("rej_high_gt", 32'(ld_err), 32'h1);
    load(3, 8, 4);
    check("rej_bad_ch", 32'(ld_err), 32'h1);
    run(2 * DP * PS);

    // Boundary high times on ch0, last-load-wins and reload on the wrap edge.
    load(0, 6, 0);
    run(3 * 6 * PS);
    load(0, 7, 2);
    load(0, 6, 6);
    run(3 * 6 * PS);
    measure_tick_interval("full_high", 6 * PS);
    load(0, DP, DH);
    run(2 * 6 * PS);

    // Enable dropped for 10 clocks during a high phase.
    measure_tick_interval("pre_freeze", DP * PS);
    run(PS + 1);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(3 * DP * PS);

    // Reset in the middle of a period, with a pending shadow load discarded.
    load(2, 3, 1);
    run(PS + 2);
    do_reset();
    measure_first_tick("rst_first_tick");
    run(2 * DP * PS);

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      int p;
      en = ($urandom_range(0, 19) != 0);
      ld = ($urandom_range(0, 9) == 0);
      ld_ch = 2'($urandom_range(0, 3));
      p = $urandom_range(0, 10);
      ld_period = CW'(p);
      ld_high = CW'($urandom_range(0, p + 2));
      step();
      ld = 1'b0;
      if ($urandom_range(0, 599) == 0) do_reset();
    end
    en = 1'b1;
    run(2 * DP * PS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
